// File: rtl/axil_adder_master.sv
// AXI4-Lite initiator for the memory-mapped adder: writes operand A and B,
// reads the result register back and returns it on a valid/ready result port.
module axil_adder_master #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    m0_axi_aclk,
  input  logic                    m0_axi_areset,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  // result port
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic [1:0]              res_resp,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]              m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [1:0]              m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready
);

  localparam logic [1:0]            RESP_OKAY = 2'b00;
  localparam logic [ADDR_WIDTH-1:0] ADDR_A    = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR_B    = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RES  = BASE_ADDR + ADDR_WIDTH'(8);

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_A_RESP,
    WR_B,
    WR_B_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   b_q;

  // A write channel is finished once its valid has dropped or is handshaking now.
  logic aw_done;
  logic w_done;
  assign aw_done = !m0_axi_awvalid || m0_axi_awready;
  assign w_done  = !m0_axi_wvalid  || m0_axi_wready;

  // NOTE: every flop in this block uses non-blocking assignments so that all
  // registered outputs update together on the edge and never race each other.
  always_ff @(posedge m0_axi_aclk) begin
    if (m0_axi_areset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      b_q            <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_resp       <= RESP_OKAY;
      m0_axi_awaddr  <= '0;
      m0_axi_awvalid <= 1'b0;
      m0_axi_wdata   <= '0;
      m0_axi_wstrb   <= '0;
      m0_axi_wvalid  <= 1'b0;
      m0_axi_bready  <= 1'b0;
      m0_axi_araddr  <= '0;
      m0_axi_arvalid <= 1'b0;
      m0_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready      <= 1'b0;
            b_q            <= cmd_b;
            res_resp       <= RESP_OKAY;
            m0_axi_awaddr  <= ADDR_A;
            m0_axi_awvalid <= 1'b1;
            m0_axi_wdata   <= cmd_a;
            m0_axi_wstrb   <= '1;
            m0_axi_wvalid  <= 1'b1;
            state          <= WR_A;
          end
        end

        WR_A, WR_B: begin
          if (m0_axi_awready) m0_axi_awvalid <= 1'b0;
          if (m0_axi_wready)  m0_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m0_axi_bready <= 1'b1;
            state         <= (state == WR_A) ? WR_A_RESP : WR_B_RESP;
          end
        end

        WR_A_RESP, WR_B_RESP: begin
          if (m0_axi_bvalid) begin
            m0_axi_bready <= 1'b0;
            if (m0_axi_bresp != RESP_OKAY) begin
              // Abort: report the write error without touching the bus again.
              res_resp  <= m0_axi_bresp;
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (state == WR_A_RESP) begin
              m0_axi_awaddr  <= ADDR_B;
              m0_axi_awvalid <= 1'b1;
              m0_axi_wdata   <= b_q;
              m0_axi_wvalid  <= 1'b1;
              state          <= WR_B;
            end else begin
              m0_axi_araddr  <= ADDR_RES;
              m0_axi_arvalid <= 1'b1;
              state          <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (m0_axi_arready) begin
            m0_axi_arvalid <= 1'b0;
            m0_axi_rready  <= 1'b1;
            state          <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m0_axi_rvalid) begin
            m0_axi_rready <= 1'b0;
            res_data      <= m0_axi_rdata;
            res_resp      <= m0_axi_rresp;
            res_valid     <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_adder_master.sv
// Self-checking bench for axil_adder_master: a delay-configurable AXI4-Lite
// adder slave plus directed and randomized command sequences.
module tb_axil_adder_master;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axil_adder_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'h00)) dut (
    .m0_axi_aclk(clk), .m0_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_resp(res_resp),
    .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
    .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
    .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
    .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- adder slave with per-channel wait cycles ----------------
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [1:0]    rresp_cfg = 2'b00;

  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic          aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] aw_q;
  logic [DW-1:0] w_q, mem_a, mem_b, rdata_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [AW-1:0] wr_log[$];
  int            ar_count = 0;
  logic          bad_strb = 1'b0, bad_araddr = 1'b0;

  logic          aw_now, w_now;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  assign aw_now  = aw_got || (awvalid && awready);
  assign w_now   = w_got  || (wvalid && wready);
  assign wr_addr = aw_got ? aw_q : awaddr;
  assign wr_data = w_got  ? w_q  : wdata;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid  && (w_cnt  >= w_delay);
  assign bvalid  = b_pend  && (b_cnt  >= b_delay);
  assign bresp   = bresp_q;
  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign rvalid  = r_pend  && (r_cnt  >= r_delay);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  always @(posedge clk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_q <= '0; w_q <= '0; mem_a <= '0; mem_b <= '0; rdata_q <= '0;
      bresp_q <= 2'b00; rresp_q <= 2'b00;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; aw_q <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_q <= wdata; w_cnt <= 0;
        if (wstrb != '1) bad_strb <= 1'b1;
      end else if (wvalid) w_cnt <= w_cnt + 1;

      if (bvalid && bready) b_pend <= 1'b0;
      else if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
      if (aw_now && w_now) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        wr_log.push_back(wr_addr);
        if (wr_addr == 8'h00) mem_a <= wr_data;
        else if (wr_addr == 8'h04) mem_b <= wr_data;
        b_pend  <= 1'b1;
        b_cnt   <= 0;
        bresp_q <= (err_en && wr_addr == err_addr) ? 2'b10 : 2'b00;
      end

      if (arvalid && arready) begin
        ar_count <= ar_count + 1;
        if (araddr != 8'h08) bad_araddr <= 1'b1;
        r_pend  <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
        rdata_q <= mem_a + mem_b;
        rresp_q <= rresp_cfg;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) r_pend <= 1'b0;
      else if (r_pend && !rvalid) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, output int e0);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    e0 = -1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin e0 = cyc + 1; break; end
      @(negedge clk);
    end
    if (e0 < 0) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int e0, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (res_valid) begin lat = cyc - e0; break; end
      @(negedge clk);
    end
    if (lat < 0) check("res_valid_timeout", 0, 1);
  endtask

  task automatic accept_res(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_res_valid_after_hs"}, res_valid, 0);
    check({tag, "_cmd_ready_after_hs"}, cmd_ready, 1);
  endtask

  // Reference: an OKAY sequence writes A then B, reads once, returns slave data.
  // Latency: each write costs (max AW/W wait + 1) + (B wait + 1); the read
  // costs (AR wait + 1) + (R wait + 1).
  task automatic run_and_check(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int e0, lat, wb, ab, exp_lat;
    logic [DW-1:0] exp_sum;
    exp_sum = a + b;
    exp_lat = 2 * (((aw_delay > w_delay) ? aw_delay : w_delay) + 1 + b_delay + 1)
              + ar_delay + 1 + r_delay + 1;
    wb = wr_log.size();
    ab = ar_count;
    send_cmd(a, b, e0);
    wait_res(e0, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, res_data, exp_sum);
    check({tag, "_resp"}, res_resp, rresp_cfg);
    check({tag, "_nwrites"}, wr_log.size() - wb, 2);
    if (wr_log.size() - wb == 2) begin
      check({tag, "_wr0_addr"}, wr_log[wb], 8'h00);
      check({tag, "_wr1_addr"}, wr_log[wb + 1], 8'h04);
    end
    check({tag, "_nreads"}, ar_count - ab, 1);
    accept_res(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, lat, wb, ab;
    logic [DW-1:0] a, b, held;

    areset = 1'b1; cmd_valid = 1'b1; cmd_a = 32'd1; cmd_b = 32'd2; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state with cmd_valid asserted throughout
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_resp", res_resp, 0);
    areset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_no_cmd_taken", awvalid, 0);

    // Basic sum with zero-wait slave
    run_and_check("basic", 32'd5, 32'd7);

    // Split write channels: AW delayed 3 cycles, W immediate
    aw_delay = 3;
    send_cmd(32'd10, 32'd20, e0);
    check("split_aw_w_rise", {awvalid, wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("split_awvalid_held", awvalid, 1);
      check("split_wvalid_dropped", wvalid, 0);
      check("split_awaddr_stable", awaddr, 8'h00);
      check("split_bready_low", bready, 0);
    end
    @(negedge clk);
    check("split_bready_after_both", {awvalid, bready}, 2'b01);
    wait_res(e0, lat);
    check("split_latency", lat, 12);
    check("split_data", res_data, 32'd30);
    accept_res("split");
    aw_delay = 0;

    // Write error on operand A
    err_en = 1'b1; err_addr = 8'h00;
    wb = wr_log.size(); ab = ar_count;
    send_cmd(32'd3, 32'd9, e0);
    wait_res(e0, lat);
    check("werr_latency", lat, 2);
    check("werr_resp", res_resp, 2'b10);
    check("werr_data", res_data, 0);
    check("werr_nwrites", wr_log.size() - wb, 1);
    check("werr_nreads", ar_count - ab, 0);
    repeat (3) @(negedge clk);
    check("werr_no_more_traffic", {awvalid, wvalid, arvalid, res_valid}, 4'b0001);
    accept_res("werr");
    err_en = 1'b0;

    // Wrap-around
    run_and_check("wrap", 32'hFFFF_FFFF, 32'd1);

    // Result backpressure for 10 cycles
    send_cmd(32'd100, 32'd23, e0);
    wait_res(e0, lat);
    held = res_data;
    check("bp_data", held, 32'd123);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid_held", res_valid, 1);
      check("bp_res_data_stable", res_data, 32'd123);
      check("bp_cmd_ready_low", cmd_ready, 0);
    end
    accept_res("bp");

    // Randomized delays, operands and read responses
    for (int n = 0; n < 16; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      a = $urandom; b = $urandom;
      run_and_check($sformatf("rand%0d", n), a, b);
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0; rresp_cfg = 2'b00;

    // Reset while waiting in RD_DATA
    r_delay = 5;
    send_cmd(32'd9, 32'd9, e0);
    for (int i = 0; i < 100 && !rready; i++) @(negedge clk);
    check("mid_rst_reached_rd", rready, 1);
    areset = 1'b1;
    @(negedge clk);
    check("mid_rst_axi_outputs", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    areset = 1'b0; r_delay = 0;
    @(negedge clk);
    run_and_check("after_rst", 32'd3, 32'd4);

    check("wstrb_all_ones", bad_strb, 0);
    check("araddr_result_reg", bad_araddr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_adder_master.md
# axil_adder_master

AXI4-Lite initiator that drives the memory-mapped adder peripheral on behalf of local logic. It accepts an operand pair on a valid/ready command port and writes operand A, then operand B, to the peripheral. It then reads back the result register and returns the read data and the AXI response on a valid/ready result port. It sits between datapath control logic and the adder slave on the m0 AXI4-Lite bus, one transaction sequence at a time.

## Interface
- DATA_WIDTH, 32, AXI data width and operand/result width; must be a multiple of 8.
- ADDR_WIDTH, 8, AXI address width.
- BASE_ADDR, 0, peripheral base address; operand A is at BASE_ADDR+0x0, operand B at +0x4, result at +0x8.

- m0_axi_aclk  in  1  single clock; every flop is clocked on its rising edge.
- m0_axi_areset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_a, cmd_b  in  DATA_WIDTH each  operands, sampled on command handshake.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_data  out  DATA_WIDTH  read data from the result register.
- res_resp  out  2  first non-OKAY response of the sequence; otherwise the RRESP of the read.
- m0_axi_awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1  write address channel.
- m0_axi_wdata / wstrb / wvalid / wready  out / out / out / in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel.
- m0_axi_bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel.
- m0_axi_araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1  read address channel.
- m0_axi_rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  read data channel.

## Operation
- **States:** IDLE, WR_A, WR_A_RESP, WR_B, WR_B_RESP, RD_ADDR, RD_DATA, DONE. All outputs are registered.
- **IDLE:** cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_a/cmd_b and go to WR_A.
- **WR_A/WR_B:** awvalid and wvalid rise together on state entry. awaddr = BASE+0x0 or BASE+0x4; wdata = latched A or B; wstrb = all ones.
  - Each valid is held, with its payload stable, until its own handshake, then drops independently.
  - Advance to the _RESP state only after both handshakes have occurred; they may occur in the same cycle or in either order.
- **_RESP states:** bready=1 until bvalid.
  - bresp==OKAY: WR_A_RESP goes to WR_B; WR_B_RESP goes to RD_ADDR.
  - bresp!=OKAY: capture it into res_resp, set res_data=0, go to DONE. No further AXI traffic is issued.
- **RD_ADDR:** arvalid=1, araddr=BASE+0x8, held until arready; then go to RD_DATA.
- **RD_DATA:** rready=1 until rvalid. Capture rdata into res_data and rresp into res_resp; go to DONE.
- **DONE:** res_valid=1, held with data stable until res_ready. Then go to IDLE.
- **Arithmetic:** none is done locally. res_data is exactly the slave's read data; any wrap-around of the sum is the slave's behaviour.
- **wstrb width:** DATA_WIDTH/8 bits.

## Timing
- **Reset values:** state=IDLE; cmd_ready=0 during reset and 1 from the first cycle after reset. All AXI valid/ready outputs = 0; awaddr, araddr, wdata = 0; wstrb = 0; res_valid=0; res_data=0; res_resp=0.
- **Reset mid-sequence:** all AXI outputs drop the cycle after reset is sampled, and in-flight data is discarded. The system is reset together, so no protocol recovery is attempted.
- **Zero-wait slave latency** (ready/valid returned the cycle after each request):
  - Command handshake at edge E0.
  - AW/W valid during E0–E1; bready during E1–E2.
  - Second write during E2–E4; AR during E4–E5; R during E5–E6.
  - res_valid=1 from E6, i.e. 6 cycles.
- Each additional slave wait cycle adds exactly one cycle.
- cmd_ready=0 in every state except IDLE. A new command is accepted at the earliest one cycle after the res handshake.
- cmd_valid arriving during reset is ignored.

## Test plan
- **Basic sum, zero-wait slave:** cmd_a=5, cmd_b=7 → writes 5 to 0x00 and 7 to 0x04, reads 0x08; res_data=12, res_resp=00; res_valid rises exactly 6 cycles after the command handshake.
- **Split write channels:** awready delayed 3 cycles, wready immediate on write A → wvalid drops after 1 cycle; awvalid and awaddr are held stable 3 cycles; bready is not asserted until both handshakes are done.
- **Write error:** bresp=2'b10 on the operand-A write → no write to 0x04 and no AR issued; res_valid with res_resp=10 and res_data=0.
- **Wrap-around:** cmd_a=0xFFFFFFFF, cmd_b=1, slave returns rdata=0 → res_data=0, res_resp=00.
- **Result backpressure:** res_ready held low for 10 cycles in DONE → res_valid and res_data stable and cmd_ready=0 throughout; IDLE and cmd_ready=1 one cycle after res_ready rises.
- **Reset mid-operation:** reset asserted during RD_DATA (rready=1) → next cycle all AXI outputs and res_valid are 0; after release, a command 3+4 completes with res_data=7.
